// File: rtl/dds_ctrl_pkg.sv
// Shared constants and helpers for the front-panel DDS frequency controller:
// step sizes, step_sel and key-FSM encodings, and Hz-to-phase-increment math.
package dds_ctrl_pkg;

    localparam logic [24:0] STEP_10HZ   = 25'd10;
    localparam logic [24:0] STEP_1KHZ   = 25'd1_000;
    localparam logic [24:0] STEP_100KHZ = 25'd100_000;
    localparam logic [24:0] STEP_1MHZ   = 25'd1_000_000;

    localparam logic [1:0] SEL_10HZ   = 2'b00;
    localparam logic [1:0] SEL_1KHZ   = 2'b01;
    localparam logic [1:0] SEL_100KHZ = 2'b10;
    localparam logic [1:0] SEL_1MHZ   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DEB   = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_RPT   = 2'd3;

    // Key code is {up, down}; 00 and 11 both mean "no key".
    localparam logic [1:0] KEY_UP   = 2'b10;
    localparam logic [1:0] KEY_DOWN = 2'b01;

    localparam int unsigned DEF_PINC_MUL   = 5_629_500;
    localparam int unsigned DEF_PINC_SHIFT = 16;

    function automatic logic [24:0] step_of(input logic [1:0] sel);
        case (sel)
            SEL_10HZ:   return STEP_10HZ;
            SEL_1KHZ:   return STEP_1KHZ;
            SEL_100KHZ: return STEP_100KHZ;
            default:    return STEP_1MHZ;
        endcase
    endfunction

    // round(2^(32+shift) / clk_hz)
    function automatic int unsigned pinc_mul_for(input longint unsigned clk_hz,
                                                 input int unsigned shift);
        longint unsigned full;
        full = (64'd1 << (32 + shift)) + clk_hz / 2;
        return 32'(full / clk_hz);
    endfunction

    function automatic logic [31:0] pinc_of(input logic [24:0] hz,
                                            input int unsigned mul = DEF_PINC_MUL,
                                            input int unsigned shift = DEF_PINC_SHIFT);
        return 32'((48'(hz) * 48'(mul)) >> shift);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Up/down key front end: 2-flop synchronisers, debounce, and delayed auto-repeat
// producing single-cycle step events with a latched direction.
module key_repeat
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_up_i,
    input  logic key_down_i,
    output logic step_evt_o,
    output logic dir_up_o
);

    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  key_code;
    logic [1:0]  latched;
    logic [1:0]  state;
    logic [31:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // which is what makes the two synchroniser stages distinct flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {key_up_i, key_down_i};
            sync2 <= sync1;
        end
    end

    assign key_code = sync2;
    assign dir_up_o = (latched == KEY_UP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            latched    <= 2'b00;
            cnt        <= 32'd0;
            step_evt_o <= 1'b0;
        end else begin
            step_evt_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_code == KEY_UP || key_code == KEY_DOWN) begin
                        latched <= key_code;
                        cnt     <= 32'd0;
                        state   <= ST_DEB;
                    end
                end
                ST_DEB: begin
                    if (key_code != latched) begin
                        state <= ST_IDLE;
                    end else if (cnt == DEBOUNCE_CYC - 1) begin
                        step_evt_o <= 1'b1;
                        cnt        <= 32'd0;
                        state      <= ST_DELAY;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DELAY: begin
                    if (key_code != latched) begin
                        state <= ST_IDLE;
                    end else if (cnt == REPEAT_DELAY_CYC - 1) begin
                        step_evt_o <= 1'b1;
                        cnt        <= 32'd0;
                        state      <= ST_RPT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    if (key_code != latched) begin
                        state <= ST_IDLE;
                    end else if (cnt == REPEAT_PERIOD_CYC - 1) begin
                        step_evt_o <= 1'b1;
                        cnt        <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dds_freq_ctrl.sv
// Front-panel frequency controller: key steps -> bounded Hz value -> DDS phase
// increment, with a one-cycle up/down trigger aligned to every word change.
module dds_freq_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ            = 50_000_000,
    parameter int unsigned PINC_SHIFT        = 16,
    parameter int unsigned PINC_MUL          = pinc_mul_for(64'(CLK_HZ), PINC_SHIFT),
    parameter int unsigned MIN_HZ            = 10,
    parameter int unsigned MAX_HZ            = 20_000_000,
    parameter int unsigned INIT_HZ           = 1_000,
    parameter int unsigned DEBOUNCE_CYC      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_up_i,
    input  logic        key_down_i,
    input  logic [1:0]  step_sel_i,
    output logic [31:0] frequency_o,
    output logic        freq_up_trigger_o,
    output logic        freq_down_trigger_o,
    output logic [24:0] freq_hz_o,
    output logic        busy_o
);

    localparam logic signed [25:0] MIN_S     = 26'(MIN_HZ);
    localparam logic signed [25:0] MAX_S     = 26'(MAX_HZ);
    localparam logic [31:0]        INIT_PINC = pinc_of(25'(INIT_HZ), PINC_MUL, PINC_SHIFT);

    logic               step_evt;
    logic               dir_up;
    logic [24:0]        freq_hz;
    logic [24:0]        next_hz;
    logic signed [25:0] cur;
    logic signed [25:0] stp;
    logic signed [25:0] sum;
    logic [47:0]        product;
    logic [3:0]         init_sr;
    logic               v0, v1, v2;
    logic               dir_q;
    logic               busy;
    logic               accept;

    key_repeat #(
        .DEBOUNCE_CYC      (DEBOUNCE_CYC),
        .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
        .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC)
    ) u_keys (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .key_up_i   (key_up_i),
        .key_down_i (key_down_i),
        .step_evt_o (step_evt),
        .dir_up_o   (dir_up)
    );

    // NOTE: every variable written here is assigned on every path, so no
    // latch is inferred; the signed 26-bit sum cannot wrap at either bound.
    always_comb begin
        cur = $signed({1'b0, freq_hz});
        stp = $signed({1'b0, step_of(step_sel_i)});
        sum = dir_up ? (cur + stp) : (cur - stp);
        if (sum > MAX_S) begin
            next_hz = 25'(MAX_HZ);
        end else if (sum < MIN_S) begin
            next_hz = 25'(MIN_HZ);
        end else begin
            next_hz = sum[24:0];
        end
    end

    assign busy   = v0 | v1 | v2;
    // Steps are ignored while a conversion is in flight, during the initial
    // load window, and when the value is already pinned at a bound.
    assign accept = step_evt && !busy && (init_sr == 4'd0) && (next_hz != freq_hz);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            freq_hz             <= 25'(INIT_HZ);
            product             <= 48'd0;
            frequency_o         <= INIT_PINC;
            freq_up_trigger_o   <= 1'b0;
            freq_down_trigger_o <= 1'b0;
            v0                  <= 1'b0;
            v1                  <= 1'b0;
            v2                  <= 1'b0;
            dir_q               <= 1'b0;
            init_sr             <= 4'b0001;
        end else begin
            init_sr <= {init_sr[2:0], 1'b0};
            v0      <= accept;
            v1      <= v0;
            v2      <= v1;
            if (accept) begin
                freq_hz <= next_hz;
                dir_q   <= dir_up;
            end
            if (v0) begin
                product <= 48'(freq_hz) * 48'(PINC_MUL);
            end
            if (v1) begin
                frequency_o <= 32'(product >> PINC_SHIFT);
            end
            freq_up_trigger_o   <= (v1 && dir_q) || init_sr[3];
            freq_down_trigger_o <= v1 && !dir_q;
        end
    end

    assign freq_hz_o = freq_hz;
    assign busy_o    = busy;

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Self-checking bench for dds_freq_ctrl with shortened debounce/repeat timing;
// expected values come from a plain-arithmetic frequency model.
module tb_dds_freq_ctrl;

    localparam int DEB    = 4;
    localparam int RD     = 20;
    localparam int RP     = 8;
    localparam int MIN_HZ = 10;
    localparam int MAX_HZ = 20_000_000;
    localparam int INIT   = 1_000;

    logic        clk;
    logic        rst;
    logic        key_up;
    logic        key_down;
    logic [1:0]  step_sel;
    logic [31:0] frequency;
    logic        up_trig;
    logic        dn_trig;
    logic [24:0] freq_hz;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int up_cnt = 0;
    int down_cnt = 0;
    int both_cnt = 0;
    int align_err = 0;
    int cyc = 0;
    int trig_q[$];
    logic [31:0] prev_freq;

    int   m_hz;
    int   n_up, n_dn, c_hz, c_tr, c_b0;
    logic busy_seen, hz_busy;

    dds_freq_ctrl #(
        .DEBOUNCE_CYC      (DEB),
        .REPEAT_DELAY_CYC  (RD),
        .REPEAT_PERIOD_CYC (RP)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .key_up_i            (key_up),
        .key_down_i          (key_down),
        .step_sel_i          (step_sel),
        .frequency_o         (frequency),
        .freq_up_trigger_o   (up_trig),
        .freq_down_trigger_o (dn_trig),
        .freq_hz_o           (freq_hz),
        .busy_o              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Trigger bookkeeping and the global trigger/data alignment rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_freq = frequency;
        end else begin
            if (up_trig) begin up_cnt++; trig_q.push_back(cyc); end
            if (dn_trig) begin down_cnt++; trig_q.push_back(cyc); end
            if (up_trig && dn_trig) both_cnt++;
            if (frequency !== prev_freq && !up_trig && !dn_trig) align_err++;
            prev_freq = frequency;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic longint unsigned ref_pinc(input longint unsigned hz);
        return (hz * 64'd5_629_500) / 64'd65_536;
    endfunction

    function automatic int model_next(input int hz, input logic up, input logic [1:0] sel);
        int step;
        int nx;
        case (sel)
            2'b00:   step = 10;
            2'b01:   step = 1_000;
            2'b10:   step = 100_000;
            default: step = 1_000_000;
        endcase
        nx = up ? hz + step : hz - step;
        if (nx > MAX_HZ) nx = MAX_HZ;
        if (nx < MIN_HZ) nx = MIN_HZ;
        return nx;
    endfunction

    // Events for a key held h cycles: one after the idle cycle plus debounce,
    // one after the repeat delay, then one every repeat period.
    function automatic int events_for_hold(input int h);
        int n;
        int o;
        n = 0;
        o = DEB + 1;
        while (o <= h) begin
            n++;
            o += (n == 1) ? RD : RP;
        end
        return n;
    endfunction

    task automatic press(input logic up, input logic dn, input logic [1:0] sel, input int len);
        int u0;
        int d0;
        logic [24:0] hz0;
        u0 = up_cnt;
        d0 = down_cnt;
        hz0 = freq_hz;
        c_hz = -1; c_tr = -1; c_b0 = -1;
        busy_seen = 1'b0; hz_busy = 1'b0;
        trig_q.delete();
        step_sel = sel; key_up = up; key_down = dn;
        for (int i = 0; i < len + 14; i++) begin
            if (i == len) begin key_up = 1'b0; key_down = 1'b0; end
            tick();
            if (busy) busy_seen = 1'b1;
            if (c_hz < 0 && freq_hz !== hz0) begin c_hz = i; hz_busy = busy; end
            if (c_tr < 0 && (up_trig || dn_trig)) c_tr = i;
            if (c_hz >= 0 && c_b0 < 0 && !busy) c_b0 = i;
        end
        n_up = up_cnt - u0;
        n_dn = down_cnt - d0;
    endtask

    task automatic expect_single(input string tag, input logic up, input logic [1:0] sel);
        int exp_hz;
        exp_hz = model_next(m_hz, up, sel);
        press(up, ~up, sel, 10);
        check({tag, "_hz"}, 64'(freq_hz), 64'(exp_hz));
        check({tag, "_pinc"}, 64'(frequency), ref_pinc(64'(exp_hz)));
        if (exp_hz != m_hz) begin
            check({tag, "_nup"}, 64'(n_up), up ? 64'd1 : 64'd0);
            check({tag, "_ndn"}, 64'(n_dn), up ? 64'd0 : 64'd1);
            check({tag, "_trig_lag"}, 64'(c_tr - c_hz), 64'd2);
            check({tag, "_busy_end"}, 64'(c_b0 - c_hz), 64'd3);
            check({tag, "_busy_on"}, 64'(hz_busy), 64'd1);
        end else begin
            check({tag, "_notrig"}, 64'(n_up + n_dn), 64'd0);
            check({tag, "_nobusy"}, 64'(busy_seen), 64'd0);
        end
        m_hz = exp_hz;
    endtask

    task automatic expect_none(input string tag, input logic up, input logic dn, input int len);
        press(up, dn, 2'b01, len);
        check({tag, "_hz"}, 64'(freq_hz), 64'(m_hz));
        check({tag, "_notrig"}, 64'(n_up + n_dn), 64'd0);
        check({tag, "_nobusy"}, 64'(busy_seen), 64'd0);
    endtask

    task automatic expect_hold(input string tag, input logic [1:0] sel, input int len);
        int ne;
        int changes;
        int hz;
        int nx;
        ne = events_for_hold(len);
        hz = m_hz;
        changes = 0;
        for (int k = 0; k < ne; k++) begin
            nx = model_next(hz, 1'b1, sel);
            if (nx != hz) changes++;
            hz = nx;
        end
        press(1'b1, 1'b0, sel, len);
        check({tag, "_hz"}, 64'(freq_hz), 64'(hz));
        check({tag, "_pinc"}, 64'(frequency), ref_pinc(64'(hz)));
        check({tag, "_nup"}, 64'(n_up), 64'(changes));
        check({tag, "_ndn"}, 64'(n_dn), 64'd0);
        check({tag, "_ntrig"}, 64'(trig_q.size()), 64'(changes));
        for (int k = 1; k < trig_q.size(); k++) begin
            check($sformatf("%s_gap%0d", tag, k), 64'(trig_q[k] - trig_q[k-1]),
                  (k == 1) ? 64'(RD) : 64'(RP));
        end
        m_hz = hz;
    endtask

    task automatic release_and_check_init(input string tag);
        int first;
        int u0;
        int d0;
        first = -1;
        u0 = up_cnt;
        d0 = down_cnt;
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (first < 0 && up_trig) first = i;
        end
        check({tag, "_latency"}, 64'(first), 64'd4);
        check({tag, "_npulse"}, 64'(up_cnt - u0), 64'd1);
        check({tag, "_ndown"}, 64'(down_cnt - d0), 64'd0);
        check({tag, "_hz"}, 64'(freq_hz), 64'(INIT));
        check({tag, "_pinc"}, 64'(frequency), 64'd85_899);
        m_hz = INIT;
    endtask

    initial begin
        rst = 1'b1;
        key_up = 1'b0;
        key_down = 1'b0;
        step_sel = 2'b00;
        tick();
        tick();

        check("rst_hz", 64'(freq_hz), 64'(INIT));
        check("rst_pinc", 64'(frequency), 64'd85_899);
        check("rst_up_trig", 64'(up_trig), 64'd0);
        check("rst_dn_trig", 64'(dn_trig), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        release_and_check_init("init");

        expect_single("up_1k", 1'b1, 2'b01);
        check("up_1k_word", 64'(frequency), 64'd171_798);
        expect_single("dn_1k", 1'b0, 2'b01);
        expect_single("dn_10", 1'b0, 2'b00);
        check("dn_10_word", 64'(frequency), 64'd85_040);
        expect_none("glitch", 1'b0, 1'b1, 3);
        expect_single("up_10", 1'b1, 2'b00);
        expect_single("clamp_min", 1'b0, 2'b01);
        check("clamp_min_word", 64'(frequency), 64'd858);
        expect_single("at_min", 1'b0, 2'b01);
        expect_single("up_from_min", 1'b1, 2'b01);
        expect_hold("hold60", 2'b00, 60);
        expect_none("both_keys", 1'b1, 1'b1, 20);

        for (int r = 0; r < 12; r++) begin
            logic [1:0] sel;
            logic       up;
            sel = 2'($urandom_range(0, 3));
            up  = 1'($urandom_range(0, 1));
            expect_single($sformatf("rnd%0d", r), up, sel);
        end

        expect_hold("hold_max", 2'b11, 200);
        check("hold_max_bound", 64'(freq_hz), 64'(MAX_HZ));
        expect_single("at_max", 1'b1, 2'b00);

        // Reset in the middle of a conversion.
        begin
            logic seen;
            seen = 1'b0;
            step_sel = 2'b00;
            key_down = 1'b1;
            for (int i = 0; i < 30 && !seen; i++) begin
                tick();
                if (busy) seen = 1'b1;
            end
            check("mid_busy_reached", 64'(seen), 64'd1);
            rst = 1'b1;
            key_down = 1'b0;
            #1;
            check("mid_rst_hz", 64'(freq_hz), 64'(INIT));
            check("mid_rst_pinc", 64'(frequency), 64'd85_899);
            check("mid_rst_busy", 64'(busy), 64'd0);
            check("mid_rst_trig", 64'(up_trig | dn_trig), 64'd0);
            tick();
            tick();
            release_and_check_init("reinit");
        end

        expect_single("post_rst_up", 1'b1, 2'b10);

        check("both_triggers_high", 64'(both_cnt), 64'd0);
        check("word_change_without_trigger", 64'(align_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
